// File: rtl/misc_cfg_pkg.sv
// -----------------------------------------------------------------------------
// misc_cfg_pkg
// Shared definitions for the misc/clock-mux tile configuration-RAM loader:
// CRAM geometry constants, the command opcode enum and the loader FSM states.
// -----------------------------------------------------------------------------
package misc_cfg_pkg;

    localparam int CRAM_ROWS_MAX = 16;
    localparam int CRAM_COLS     = 4;
    localparam int CRAM_RW       = $clog2(CRAM_ROWS_MAX);

    typedef enum logic [1:0] {
        END_CFG = 2'b00,
        CLEAR   = 2'b01,
        WRITE   = 2'b10,
        READ    = 2'b11
    } cfg_op_e;

    typedef enum logic [3:0] {
        PWRUP,
        CLR,
        IDLE,
        WR_SET,
        WR_PULSE,
        WR_HOLD,
        RD_SET,
        RD_PULSE,
        DONE
    } cfg_state_e;

endpackage

// File: rtl/misc_cfg_pwrseq.sv
// -----------------------------------------------------------------------------
// misc_cfg_pwrseq
// Staggered CRAM row power-up. After reset, one vdd_cntl bit is pulled low per
// clock in ascending row order, so all 16 rows are powered 16 edges after reset
// is released. Every physical row is sequenced regardless of how many rows the
// loader actually uses.
//
// Ports:
//   clk        in   block clock
//   reset      in   asynchronous active-high reset (restarts the sequence)
//   vdd_cntl   out  per-row supply PMOS gate, registered; 0 = powered
//   done       out  registered; high once every row is powered
//   last_step  out  combinational; high in the cycle whose closing edge powers
//                   the final row, so the loader can leave power-up on that
//                   same edge
// -----------------------------------------------------------------------------
module misc_cfg_pwrseq
    import misc_cfg_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    output logic [CRAM_ROWS_MAX-1:0] vdd_cntl,
    output logic                     done,
    output logic                     last_step
);

    logic [CRAM_RW-1:0]       idx_q, idx_d;
    logic [CRAM_ROWS_MAX-1:0] vdd_cntl_q, vdd_cntl_d;
    logic                     done_q, done_d;

    always_comb begin
        idx_d      = idx_q;
        vdd_cntl_d = vdd_cntl_q;
        done_d     = done_q;
        last_step  = 1'b0;
        if (!done_q) begin
            vdd_cntl_d[idx_q] = 1'b0;
            idx_d             = idx_q + 1'b1;
            if (idx_q == CRAM_RW'(CRAM_ROWS_MAX - 1)) begin
                done_d    = 1'b1;
                last_step = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            vdd_cntl_q <= '1;
            done_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            vdd_cntl_q <= vdd_cntl_d;
            done_q     <= done_d;
        end
    end

    assign vdd_cntl = vdd_cntl_q;
    assign done     = done_q;

endmodule

// File: rtl/misc_cfg_loader.sv
// -----------------------------------------------------------------------------
// misc_cfg_loader
// Row-level sequencer in front of the misc/clock-mux tile's 16x4 CRAM. Accepts
// END_CFG / CLEAR / WRITE / READ commands over valid/ready and produces
// correctly ordered, pulse-timed drive on vdd_cntl, reset_b, pgate, wl and the
// bitlines, and owns the tile's prog signal. Out of reset it powers the rows up
// one at a time, clears the array, and only then raises cmd_ready.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (accept = valid && ready)
//   cmd_op/row/data     opcode, target row, write data
//   rd_valid, rd_data   one-cycle read-result strobe and data
//   err                 one-cycle strobe for a rejected command
//   bl_out, bl_oe       bitline drive value and driver enable
//   bl_in               sensed bitline value
//   wl, pgate           one-hot wordline / pass gate per row, active-high
//   reset_b             CRAM row reset, active-low
//   vdd_cntl            row supply gate, 0 = powered
//   prog                1 while the tile is in configuration mode
// All outputs are registered.
// -----------------------------------------------------------------------------
module misc_cfg_loader
    import misc_cfg_pkg::*;
#(
    parameter int ROWS       = CRAM_ROWS_MAX,
    parameter int COLS       = CRAM_COLS,
    parameter int WL_PULSE   = 4,
    parameter int CLR_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CRAM_RW-1:0]       cmd_row,
    input  logic [COLS-1:0]          cmd_data,
    output logic                     rd_valid,
    output logic [COLS-1:0]          rd_data,
    output logic                     err,
    output logic [COLS-1:0]          bl_out,
    output logic                     bl_oe,
    input  logic [COLS-1:0]          bl_in,
    output logic [CRAM_ROWS_MAX-1:0] wl,
    output logic [CRAM_ROWS_MAX-1:0] pgate,
    output logic [CRAM_ROWS_MAX-1:0] reset_b,
    output logic [CRAM_ROWS_MAX-1:0] vdd_cntl,
    output logic                     prog
);

    localparam int CNT_MAX = (WL_PULSE > CLR_CYCLES) ? WL_PULSE : CLR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CRAM_RW:0] ROWS_LIM = (CRAM_RW + 1)'(ROWS);

    cfg_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [COLS-1:0]          sample_q, sample_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     err_q, err_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [COLS-1:0]          rd_data_q, rd_data_d;
    logic [CRAM_ROWS_MAX-1:0] wl_q, wl_d;
    logic [CRAM_ROWS_MAX-1:0] pgate_q, pgate_d;
    logic                     bl_oe_q, bl_oe_d;
    logic [COLS-1:0]          bl_out_q, bl_out_d;
    logic [CRAM_ROWS_MAX-1:0] reset_b_q, reset_b_d;
    logic                     prog_q, prog_d;

    logic                     pwr_done;
    logic                     pwr_last;
    logic                     accept;
    logic                     row_ok;
    cfg_op_e                  op;
    logic [CRAM_ROWS_MAX-1:0] row_dec;

    misc_cfg_pwrseq u_pwrseq (
        .clk       (clk),
        .reset     (reset),
        .vdd_cntl  (vdd_cntl),
        .done      (pwr_done),
        .last_step (pwr_last)
    );

    // Row decoder: one pass gate per physical row.
    generate
        for (genvar gi = 0; gi < CRAM_ROWS_MAX; gi++) begin : g_row_dec
            assign row_dec[gi] = (cmd_row == CRAM_RW'(gi));
        end
    endgenerate

    assign accept = cmd_valid && cmd_ready_q;
    assign op     = cfg_op_e'(cmd_op);
    assign row_ok = ({1'b0, cmd_row} < ROWS_LIM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        cmd_ready_d = cmd_ready_q;
        err_d       = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        wl_d        = wl_q;
        pgate_d     = pgate_q;
        bl_oe_d     = bl_oe_q;
        bl_out_d    = bl_out_q;
        reset_b_d   = reset_b_q;
        prog_d      = prog_q;

        case (state_q)
            PWRUP: begin
                // Leave on the edge that powers the last row; reset_b is
                // still low from reset, so the clear window starts at once.
                if (pwr_last && !pwr_done) begin
                    state_d = CLR;
                    cnt_d   = CNT_W'(CLR_CYCLES - 1);
                end
            end

            CLR: begin
                if (cnt_q == '0) begin
                    reset_b_d   = '1;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    // Ready drops for at least one cycle on every accepted
                    // command, including the single-cycle ones.
                    cmd_ready_d = 1'b0;
                    case (op)
                        END_CFG: begin
                            prog_d  = 1'b0;
                            state_d = DONE;
                        end
                        CLEAR: begin
                            reset_b_d = '0;
                            cnt_d     = CNT_W'(CLR_CYCLES - 1);
                            state_d   = CLR;
                        end
                        default: begin
                            if (!row_ok) begin
                                err_d = 1'b1;
                            end else if (op == WRITE) begin
                                pgate_d  = row_dec;
                                bl_oe_d  = 1'b1;
                                bl_out_d = cmd_data;
                                state_d  = WR_SET;
                            end else begin
                                pgate_d  = row_dec;
                                bl_oe_d  = 1'b0;
                                state_d  = RD_SET;
                            end
                        end
                    endcase
                end
            end

            WR_SET: begin
                wl_d    = pgate_q;
                cnt_d   = CNT_W'(WL_PULSE - 1);
                state_d = WR_PULSE;
            end

            WR_PULSE: begin
                if (cnt_q == '0) begin
                    wl_d    = '0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            WR_HOLD: begin
                pgate_d     = '0;
                bl_oe_d     = 1'b0;
                bl_out_d    = '0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end

            RD_SET: begin
                wl_d    = pgate_q;
                cnt_d   = CNT_W'(WL_PULSE - 1);
                state_d = RD_PULSE;
            end

            RD_PULSE: begin
                // Two phases distinguished by the wordline: while wl is high
                // count the pulse and capture bl_in in its last cycle; the
                // following cycle (wl low, pass gate still on) publishes the
                // captured value.
                if (wl_q != '0) begin
                    if (cnt_q == '0) begin
                        sample_d = bl_in;
                        wl_d     = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else begin
                    pgate_d     = '0;
                    rd_data_d   = sample_q;
                    rd_valid_d  = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            DONE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    case (op)
                        CLEAR: begin
                            prog_d    = 1'b1;
                            reset_b_d = '0;
                            cnt_d     = CNT_W'(CLR_CYCLES - 1);
                            state_d   = CLR;
                        end
                        END_CFG: begin
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end

            default: begin
                state_d = PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            sample_q    <= '0;
            cmd_ready_q <= 1'b0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            wl_q        <= '0;
            pgate_q     <= '0;
            bl_oe_q     <= 1'b0;
            bl_out_q    <= '0;
            reset_b_q   <= '0;
            prog_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            cmd_ready_q <= cmd_ready_d;
            err_q       <= err_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            wl_q        <= wl_d;
            pgate_q     <= pgate_d;
            bl_oe_q     <= bl_oe_d;
            bl_out_q    <= bl_out_d;
            reset_b_q   <= reset_b_d;
            prog_q      <= prog_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign err       = err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wl        = wl_q;
    assign pgate     = pgate_q;
    assign bl_oe     = bl_oe_q;
    assign bl_out    = bl_out_q;
    assign reset_b   = reset_b_q;
    assign prog      = prog_q;

endmodule

// File: tb/tb_misc_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_misc_cfg_loader
// Randomized bench for misc_cfg_loader (ROWS=12, WL_PULSE=4, CLR_CYCLES=8).
// The reference model describes each accepted command as a timeline measured
// in edges since acceptance, plus a CRAM content array, and predicts every
// output after every clock edge. It also drives bl_in as the CRAM would.
// -----------------------------------------------------------------------------
module tb_misc_cfg_loader;

    localparam int ROWS = 12;
    localparam int COLS = 4;
    localparam int WL   = 4;
    localparam int CLRC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_row = 4'd0;
    logic [3:0]  cmd_data = 4'd0;
    logic        rd_valid;
    logic [3:0]  rd_data;
    logic        err;
    logic [3:0]  bl_out;
    logic        bl_oe;
    logic [3:0]  bl_in = 4'd0;
    logic [15:0] wl, pgate, reset_b, vdd_cntl;
    logic        prog;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    misc_cfg_loader #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .WL_PULSE   (WL),
        .CLR_CYCLES (CLRC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_data  (cmd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .bl_out    (bl_out),
        .bl_oe     (bl_oe),
        .bl_in     (bl_in),
        .wl        (wl),
        .pgate     (pgate),
        .reset_b   (reset_b),
        .vdd_cntl  (vdd_cntl),
        .prog      (prog)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_PWRUP, K_CLEAR, K_WRITE, K_READ, K_ERR, K_NOP} kind_e;

    kind_e      m_kind;
    int         m_a;
    int         m_row;
    logic [3:0] m_data;
    int         edge_n;
    logic       m_prog;
    logic [3:0] m_rd_data;
    logic       m_ready;
    logic [3:0] mem [16];

    function automatic void model_reset();
        m_kind    = K_PWRUP;
        m_a       = 0;
        m_row     = 0;
        m_data    = 4'd0;
        edge_n    = 0;
        m_prog    = 1'b1;
        m_rd_data = 4'd0;
        m_ready   = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    endfunction

    function automatic void model_accept(input logic [1:0] op, input logic [3:0] row,
                                         input logic [3:0] data);
        m_a    = edge_n;
        m_row  = int'(row);
        m_data = data;
        if (!m_prog) begin
            if (op == 2'b01) begin
                m_prog = 1'b1;
                m_kind = K_CLEAR;
                for (int i = 0; i < 16; i++) mem[i] = 4'd0;
            end else if (op == 2'b00) begin
                m_kind = K_NOP;
            end else begin
                m_kind = K_ERR;
            end
        end else if (op == 2'b00) begin
            m_prog = 1'b0;
            m_kind = K_NOP;
        end else if (op == 2'b01) begin
            m_kind = K_CLEAR;
            for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        end else if (int'(row) >= ROWS) begin
            m_kind = K_ERR;
        end else if (op == 2'b10) begin
            m_kind = K_WRITE;
            mem[row] = data;
        end else begin
            m_kind = K_READ;
        end
    endfunction

    task automatic model_check();
        int          d;
        logic [15:0] oh, e_wl, e_pg, e_rstb, e_vdd;
        logic        e_oe, e_err, e_rv, e_rdy, chk_pg;
        d      = edge_n - m_a;
        oh     = 16'd1 << m_row;
        e_wl   = 16'd0;
        e_pg   = 16'd0;
        e_rstb = 16'hFFFF;
        e_oe   = 1'b0;
        e_err  = 1'b0;
        e_rv   = 1'b0;
        e_rdy  = 1'b1;
        chk_pg = 1'b1;
        case (m_kind)
            K_PWRUP: begin
                e_rstb = (d >= 16 + CLRC) ? 16'hFFFF : 16'h0000;
                e_rdy  = (d >= 16 + CLRC);
            end
            K_CLEAR: begin
                e_rstb = (d >= CLRC) ? 16'hFFFF : 16'h0000;
                e_rdy  = (d >= CLRC);
            end
            K_WRITE: begin
                if (d <= WL + 1) begin
                    e_pg = oh;
                    e_oe = 1'b1;
                end
                if (d >= 1 && d <= WL) e_wl = oh;
                e_rdy = (d >= WL + 2);
            end
            K_READ: begin
                if (d <= WL) e_pg = oh;
                if (d == WL + 1) chk_pg = 1'b0;
                if (d >= 1 && d <= WL) e_wl = oh;
                if (d == WL + 2) begin
                    e_rv = 1'b1;
                    m_rd_data = mem[m_row];
                end
                e_rdy = (d >= WL + 2);
            end
            K_ERR: begin
                e_err = (d == 0);
                e_rdy = (d >= 1);
            end
            default: begin
                e_rdy = (d >= 1);
            end
        endcase
        e_vdd = (edge_n >= 16) ? 16'h0000 : (16'hFFFF << edge_n);

        chk("vdd_cntl", vdd_cntl, e_vdd);
        chk("reset_b", reset_b, e_rstb);
        chk("cmd_ready", cmd_ready, e_rdy);
        chk("prog", prog, m_prog);
        chk("wl", wl, e_wl);
        if (chk_pg) chk("pgate", pgate, e_pg);
        chk("bl_oe", bl_oe, e_oe);
        if (e_oe) chk("bl_out", bl_out, m_data);
        chk("err", err, e_err);
        chk("rd_valid", rd_valid, e_rv);
        chk("rd_data", rd_data, m_rd_data);
        chk("wl_onehot", ($countones(wl) <= 1), 1'b1);
        chk("pgate_onehot", ($countones(pgate) <= 1), 1'b1);
        chk("wl_without_pgate", wl & ~pgate, 16'd0);
        m_ready = e_rdy;
        // The CRAM presents the addressed row only in the last wordline cycle.
        if (m_kind == K_READ && d == WL) bl_in = mem[m_row];
        else                              bl_in = 4'($urandom);
    endtask

    // Compare process: one prediction and check after every clock edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) begin
                edge_n++;
                if (cmd_valid && m_ready) model_accept(cmd_op, cmd_row, cmd_data);
                #2;
                if (!reset) model_check();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] op, input logic [3:0] row, input logic [3:0] data);
        int t;
        t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_data  = data;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("handshake_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
        end else begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_row   = 4'($urandom);
            cmd_data  = 4'($urandom);
        end
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, cmd_ready, 1'b1);
    endtask

    task automatic random_cmds(input int count);
        int         r;
        logic [1:0] op;
        for (int k = 0; k < count; k++) begin
            r  = $urandom_range(0, 9);
            op = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r <= 5) ? 2'b10 : 2'b11;
            send(op, 4'($urandom_range(0, 15)), 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        int t;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_vdd_cntl", vdd_cntl, 16'hFFFF);
        chk("rst_reset_b", reset_b, 16'h0000);
        chk("rst_wl", wl, 16'h0000);
        chk("rst_pgate", pgate, 16'h0000);
        chk("rst_prog", prog, 1'b1);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_bl_oe", bl_oe, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;

        // Literal power-up / clear timeline.
        @(posedge clk); #3;
        chk("pwrup_edge1", vdd_cntl, 16'hFFFE);
        repeat (7) @(posedge clk); #3;
        chk("pwrup_edge8", vdd_cntl, 16'hFF00);
        repeat (8) @(posedge clk); #3;
        chk("pwrup_edge16", vdd_cntl, 16'h0000);
        repeat (7) @(posedge clk); #3;
        chk("clr_edge23_reset_b", reset_b, 16'h0000);
        chk("clr_edge23_ready", cmd_ready, 1'b0);
        @(posedge clk); #3;
        chk("clr_edge24_reset_b", reset_b, 16'hFFFF);
        chk("clr_edge24_ready", cmd_ready, 1'b1);

        // Write row 5 with 4'hA.
        send(2'b10, 4'd5, 4'hA);
        chk("wr_d0_pgate", pgate, 16'h0020);
        chk("wr_d0_bl_out", bl_out, 4'hA);
        @(negedge clk);
        chk("wr_d1_wl", wl, 16'h0020);

        // Read row 5 back.
        send(2'b11, 4'd5, 4'h0);
        t = 0;
        while (!rd_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rd_latency", t, 6);
        chk("rd_data_lit", rd_data, 4'hA);

        // Out-of-range row (ROWS=12).
        send(2'b10, 4'd13, 4'h3);
        chk("oor_err", err, 1'b1);
        chk("oor_pgate", pgate, 16'h0000);

        // End of config, then rejection and re-entry from DONE.
        send(2'b00, 4'd0, 4'h0);
        chk("endcfg_prog", prog, 1'b0);
        send(2'b10, 4'd2, 4'h7);
        chk("done_wr_err", err, 1'b1);
        chk("done_wr_pgate", pgate, 16'h0000);
        send(2'b00, 4'd0, 4'h0);
        send(2'b01, 4'd0, 4'h0);
        chk("done_clr_prog", prog, 1'b1);
        chk("done_clr_reset_b", reset_b, 16'h0000);

        random_cmds(70);

        // Reset in the middle of a write pulse.
        send(2'b01, 4'd0, 4'h0);
        send(2'b10, 4'd3, 4'h5);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_wl", wl, 16'h0000);
        chk("midrst_pgate", pgate, 16'h0000);
        chk("midrst_vdd_cntl", vdd_cntl, 16'hFFFF);
        chk("midrst_reset_b", reset_b, 16'h0000);
        chk("midrst_bl_oe", bl_oe, 1'b0);
        chk("midrst_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #3;
        chk("rerun_edge1", vdd_cntl, 16'hFFFE);
        wait_ready("rerun_ready_timeout");

        random_cmds(20);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
